// File: rtl/magnitude_comparator_pkg.sv
// Shared types and helpers for the sequential magnitude comparator.
// Holds the FSM state encoding and the signed-to-offset-binary operand map.
package magnitude_comparator_pkg;

  // Widest operand the flip_msb helper can handle.
  localparam int MAX_W = 64;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // Inverting the sign bit turns two's-complement order into unsigned order.
  function automatic logic [MAX_W-1:0] flip_msb(input logic [MAX_W-1:0] v,
                                                input int width);
    logic [MAX_W-1:0] mask;
    mask = MAX_W'(1) << (width - 1);
    return v ^ mask;
  endfunction

endpackage

// File: rtl/magnitude_digit_cmp.sv
// Combinational unsigned compare of one DIGIT-bit slice.
// Generalises the original 4-bit magnitude comparator to any digit width.
module magnitude_digit_cmp #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  output logic             eq,
  output logic             gt
);

  assign eq = (a == b);
  assign gt = (a > b);

endmodule

// File: rtl/magnitude_comparator_seq.sv
// Multi-cycle MSB-first magnitude comparator: DIGIT bits per cycle, early exit
// on the first differing digit, registered eq/gt/lt flags and a done pulse.
module magnitude_comparator_seq
  import magnitude_comparator_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGIT  = 1,
  parameter int SIGNED = 0
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic [WIDTH-1:0]                    data_a,
  input  logic [WIDTH-1:0]                    data_b,
  output logic                                busy,
  output logic                                done,
  output logic                                aeqb,
  output logic                                agtb,
  output logic                                altb,
  output logic [$clog2(WIDTH/DIGIT+1)-1:0]    digits_used
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int CNT_W = $clog2(NDIG + 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sa_q, sa_d;
  logic [WIDTH-1:0]   sb_q, sb_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   du_q, du_d;
  logic               eq_q, eq_d;
  logic               gt_q, gt_d;
  logic               lt_q, lt_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   load_a, load_b;
  logic               dig_eq, dig_gt;
  logic               last_dig;

  // Operand mapping applied once at capture time.
  always_comb begin
    load_a = data_a;
    load_b = data_b;
    if (SIGNED != 0) begin
      load_a = WIDTH'(flip_msb(MAX_W'(data_a), WIDTH));
      load_b = WIDTH'(flip_msb(MAX_W'(data_b), WIDTH));
    end
  end

  magnitude_digit_cmp #(
    .DIGIT (DIGIT)
  ) u_digit_cmp (
    .a  (sa_q[WIDTH-1 -: DIGIT]),
    .b  (sb_q[WIDTH-1 -: DIGIT]),
    .eq (dig_eq),
    .gt (dig_gt)
  );

  assign last_dig = (cnt_q == CNT_W'(NDIG - 1));

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    cnt_d   = cnt_q;
    du_d    = du_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          sa_d    = load_a;
          sb_d    = load_b;
          cnt_d   = '0;
          du_d    = '0;
          eq_d    = 1'b0;
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        cnt_d = cnt_q + 1'b1;
        if (!dig_eq) begin
          gt_d    = dig_gt;
          lt_d    = !dig_gt;
          du_d    = cnt_q + 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (last_dig) begin
          eq_d    = 1'b1;
          du_d    = CNT_W'(NDIG);
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          // Bring the next digit into the compared top slice.
          sa_d = sa_q << DIGIT;
          sb_d = sb_q << DIGIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      cnt_q   <= '0;
      du_q    <= '0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
      du_q    <= du_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      done_q  <= done_d;
    end
  end

  assign busy        = (state_q == SCAN);
  assign done        = done_q;
  assign aeqb        = eq_q;
  assign agtb        = gt_q;
  assign altb        = lt_q;
  assign digits_used = du_q;

endmodule
